// File: rtl/dpc_judge_3x3.sv
// dpc_judge_3x3
// Defect-pixel decision and correction stage of the DPC core. It takes the
// signed centre-minus-neighbour deltas of a 3x3 window and flags the centre
// as hot (all deltas > 0) or dead (all deltas < 0) when every |delta| is
// strictly above the threshold. A flagged centre is replaced by the rounded
// mean of its four axial neighbours when correction is enabled. A saturating
// per-frame defect count is kept alongside.
//
// Ports:
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   i_line_valid          input window valid
//   i_line3_1/2/3         {d1,d2,d3}, {d4,{1'b0,centre},d6}, {d7,d8,d9};
//                         9-bit signed fields, MSB field first
//   i_threshold           unsigned detection threshold (sampled with window)
//   i_dpc_en              1 = correct, 0 = bypass (sampled with window)
//   i_frame_start         single-cycle pulse, clears the defect counter
//   o_line_valid          output pixel valid, 3 clk after i_line_valid
//   o_pixel               corrected or passed-through centre pixel
//   o_defect              centre classified defective (also when bypassed)
//   o_defect_cnt          defects counted since the last i_frame_start
//
// Handshake: valid-only streaming with no ready/backpressure. A window is
// consumed on every clk where i_line_valid = 1, and its result is presented
// exactly 3 clk later with o_line_valid = 1. The data path free-runs, so the
// data outputs are meaningful only while o_line_valid = 1.
module dpc_judge_3x3 #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_line_valid,
  input  logic [26:0]          i_line3_1,
  input  logic [26:0]          i_line3_2,
  input  logic [26:0]          i_line3_3,
  input  logic [7:0]           i_threshold,
  input  logic                 i_dpc_en,
  input  logic                 i_frame_start,
  output logic                 o_line_valid,
  output logic [7:0]           o_pixel,
  output logic                 o_defect,
  output logic [CNT_WIDTH-1:0] o_defect_cnt
);

  // Deltas in order d1,d2,d3,d4,d6,d7,d8,d9.
  logic [7:0][8:0] delta;
  logic [7:0]      centre;
  // The top bit of the centre field is always zero and carries no data.
  logic            unused_centre_msb;

  // Valid pipe
  logic [2:0] vld_d, vld_q;
  // Stage 1
  logic [7:0][8:0] s1_abs_d, s1_abs_q;
  logic            s1_all_pos_d, s1_all_pos_q;
  logic            s1_all_neg_d, s1_all_neg_q;
  logic [3:0][7:0] s1_nb_d, s1_nb_q;  // n2, n4, n6, n8
  logic [7:0]      s1_centre_d, s1_centre_q;
  logic [7:0]      s1_thr_d, s1_thr_q;
  logic            s1_en_d, s1_en_q;
  // Stage 2
  logic            s2_defect_d, s2_defect_q;
  logic [7:0]      s2_repl_d, s2_repl_q;
  logic [7:0]      s2_centre_d, s2_centre_q;
  logic            s2_en_d, s2_en_q;
  // Stage 3
  logic [7:0]      s3_pixel_d, s3_pixel_q;
  logic            s3_defect_d, s3_defect_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  logic       over;
  logic       cnt_inc;
  logic [9:0] s2_sum;
  logic [9:0] s2_sum_rnd;

  assign unused_centre_msb = i_line3_2[17];

  always_comb begin
    delta[0] = i_line3_1[26:18];
    delta[1] = i_line3_1[17:9];
    delta[2] = i_line3_1[8:0];
    delta[3] = i_line3_2[26:18];
    delta[4] = i_line3_2[8:0];
    delta[5] = i_line3_3[26:18];
    delta[6] = i_line3_3[17:9];
    delta[7] = i_line3_3[8:0];
    centre   = i_line3_2[16:9];
  end

  always_comb begin
    vld_d = {vld_q[1:0], i_line_valid};

    // Stage 1: magnitudes, sign uniformity, axial neighbour reconstruction.
    s1_all_pos_d = 1'b1;
    s1_all_neg_d = 1'b1;
    s1_abs_d     = '0;
    for (int k = 0; k < 8; k++) begin
      s1_abs_d[k]  = delta[k][8] ? (~delta[k] + 9'd1) : delta[k];
      s1_all_pos_d = s1_all_pos_d & ~delta[k][8] & (delta[k] != 9'd0);
      s1_all_neg_d = s1_all_neg_d & delta[k][8];
    end
    // nk = centre - dk always lands in 0..255, so 8-bit wraparound is exact.
    s1_nb_d[0]  = centre - delta[1][7:0];
    s1_nb_d[1]  = centre - delta[3][7:0];
    s1_nb_d[2]  = centre - delta[4][7:0];
    s1_nb_d[3]  = centre - delta[6][7:0];
    s1_centre_d = centre;
    s1_thr_d    = i_threshold;
    s1_en_d     = i_dpc_en;

    // Stage 2: threshold test and rounded axial mean.
    over = 1'b1;
    for (int k = 0; k < 8; k++) begin
      over = over & (s1_abs_q[k] > {1'b0, s1_thr_q});
    end
    s2_defect_d = (s1_all_pos_q | s1_all_neg_q) & over;
    s2_sum      = {2'b00, s1_nb_q[0]} + {2'b00, s1_nb_q[1]}
                + {2'b00, s1_nb_q[2]} + {2'b00, s1_nb_q[3]};
    // Max 4*255+2 = 1022 fits in 10 bits, so the shifted result fits 8 bits.
    s2_sum_rnd  = s2_sum + 10'd2;
    s2_repl_d   = s2_sum_rnd[9:2];
    s2_centre_d = s1_centre_q;
    s2_en_d     = s1_en_q;

    // Stage 3: output select; defect flag qualified by the valid that
    // reaches o_line_valid on the same edge.
    s3_pixel_d  = (s2_defect_q & s2_en_q) ? s2_repl_q : s2_centre_q;
    s3_defect_d = s2_defect_q & vld_q[1];

    // The counter increments on exactly the edge that raises o_defect, so
    // o_defect and o_defect_cnt always agree. A frame start restarts the
    // count, but a defect landing on that same edge belongs to the new frame.
    cnt_inc = s2_defect_q & vld_q[1];
    cnt_d   = cnt_q;
    if (i_frame_start) begin
      cnt_d = {{(CNT_WIDTH-1){1'b0}}, cnt_inc};
    end else if (cnt_inc && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q        <= '0;
      s1_abs_q     <= '0;
      s1_all_pos_q <= 1'b0;
      s1_all_neg_q <= 1'b0;
      s1_nb_q      <= '0;
      s1_centre_q  <= '0;
      s1_thr_q     <= '0;
      s1_en_q      <= 1'b0;
      s2_defect_q  <= 1'b0;
      s2_repl_q    <= '0;
      s2_centre_q  <= '0;
      s2_en_q      <= 1'b0;
      s3_pixel_q   <= '0;
      s3_defect_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      vld_q        <= vld_d;
      s1_abs_q     <= s1_abs_d;
      s1_all_pos_q <= s1_all_pos_d;
      s1_all_neg_q <= s1_all_neg_d;
      s1_nb_q      <= s1_nb_d;
      s1_centre_q  <= s1_centre_d;
      s1_thr_q     <= s1_thr_d;
      s1_en_q      <= s1_en_d;
      s2_defect_q  <= s2_defect_d;
      s2_repl_q    <= s2_repl_d;
      s2_centre_q  <= s2_centre_d;
      s2_en_q      <= s2_en_d;
      s3_pixel_q   <= s3_pixel_d;
      s3_defect_q  <= s3_defect_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_line_valid = vld_q[2];
  assign o_pixel      = s3_pixel_q;
  assign o_defect     = s3_defect_q;
  assign o_defect_cnt = cnt_q;

endmodule

// File: tb/tb_dpc_judge_3x3.sv
// Testbench for dpc_judge_3x3. Two instances share one stimulus stream: the
// default 16-bit counter and a 4-bit counter for saturation. Windows are
// described by centre and neighbour pixel values; the reference model works
// from those pixels directly.
module tb_dpc_judge_3x3;

  typedef struct packed {
    logic       valid;
    logic       defect;
    logic [7:0] pixel;
  } exp_t;

  // Clock / reset
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs
  logic        i_line_valid;
  logic [26:0] i_line3_1, i_line3_2, i_line3_3;
  logic [7:0]  i_threshold;
  logic        i_dpc_en;
  logic        i_frame_start;
  // DUT outputs
  logic        o_line_valid, o_line_valid4;
  logic [7:0]  o_pixel, o_pixel4;
  logic        o_defect, o_defect4;
  logic [15:0] o_defect_cnt;
  logic [3:0]  o_defect_cnt4;

  dpc_judge_3x3 #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_line_valid(i_line_valid),
    .i_line3_1(i_line3_1), .i_line3_2(i_line3_2), .i_line3_3(i_line3_3),
    .i_threshold(i_threshold), .i_dpc_en(i_dpc_en),
    .i_frame_start(i_frame_start), .o_line_valid(o_line_valid),
    .o_pixel(o_pixel), .o_defect(o_defect), .o_defect_cnt(o_defect_cnt)
  );

  dpc_judge_3x3 #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_line_valid(i_line_valid),
    .i_line3_1(i_line3_1), .i_line3_2(i_line3_2), .i_line3_3(i_line3_3),
    .i_threshold(i_threshold), .i_dpc_en(i_dpc_en),
    .i_frame_start(i_frame_start), .o_line_valid(o_line_valid4),
    .o_pixel(o_pixel4), .o_defect(o_defect4), .o_defect_cnt(o_defect_cnt4)
  );

  // Current window (neighbour order n1,n2,n3,n4,n6,n7,n8,n9) and controls.
  logic [7:0] win_c;
  logic [7:0] win_n [8];
  logic       cur_valid, cur_en, cur_fs;
  logic [7:0] cur_thr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dlt(input logic [7:0] c, input logic [7:0] n);
    return {1'b0, c} - {1'b0, n};
  endfunction

  // Driver: present the current window/controls on the DUT pins.
  task automatic drive();
    i_line_valid  = cur_valid;
    i_line3_1     = {dlt(win_c, win_n[0]), dlt(win_c, win_n[1]), dlt(win_c, win_n[2])};
    i_line3_2     = {dlt(win_c, win_n[3]), {1'b0, win_c}, dlt(win_c, win_n[4])};
    i_line3_3     = {dlt(win_c, win_n[5]), dlt(win_c, win_n[6]), dlt(win_c, win_n[7])};
    i_threshold   = cur_thr;
    i_dpc_en      = cur_en;
    i_frame_start = cur_fs;
  endtask

  task automatic set_uniform(input logic [7:0] c, input logic [7:0] n);
    win_c = c;
    for (int k = 0; k < 8; k++) win_n[k] = n;
  endtask

  // Reference model: classification from pixel values.
  function automatic exp_t model_now();
    exp_t r;
    logic pos, neg, over, flag;
    int   diff, sum;
    pos = 1'b1; neg = 1'b1; over = 1'b1;
    for (int k = 0; k < 8; k++) begin
      diff = int'(win_c) - int'(win_n[k]);
      pos  = pos & (diff > 0);
      neg  = neg & (diff < 0);
      if (diff < 0) diff = -diff;
      over = over & (diff > int'(cur_thr));
    end
    sum      = int'(win_n[1]) + int'(win_n[3]) + int'(win_n[4]) + int'(win_n[6]);
    flag     = (pos | neg) & over;
    r.valid  = cur_valid;
    r.defect = cur_valid & flag;
    r.pixel  = (flag & cur_en) ? 8'((sum + 2) / 4) : win_c;
    return r;
  endfunction

  // Expected-result pipe: pipe[2] is what the outputs show after an edge.
  exp_t        pipe [3];
  logic [15:0] m_cnt16;
  logic [3:0]  m_cnt4;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
      m_cnt16 <= '0; m_cnt4 <= '0;
    end else begin
      pipe[0] <= model_now();
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (cur_fs) begin
        m_cnt16 <= {15'd0, pipe[1].defect};
        m_cnt4  <= {3'd0, pipe[1].defect};
      end else if (pipe[1].defect) begin
        if (m_cnt16 != 16'hFFFF) m_cnt16 <= m_cnt16 + 16'd1;
        if (m_cnt4 != 4'hF)      m_cnt4  <= m_cnt4 + 4'd1;
      end
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    chk("valid", 32'(o_line_valid), 32'(pipe[2].valid));
    chk("valid4", 32'(o_line_valid4), 32'(pipe[2].valid));
    chk("defect", 32'(o_defect), 32'(pipe[2].defect));
    chk("defect4", 32'(o_defect4), 32'(pipe[2].defect));
    if (pipe[2].valid) begin
      chk("pixel", 32'(o_pixel), 32'(pipe[2].pixel));
      chk("pixel4", 32'(o_pixel4), 32'(pipe[2].pixel));
    end
    chk("cnt16", 32'(o_defect_cnt), 32'(m_cnt16));
    chk("cnt4", 32'(o_defect_cnt4), 32'(m_cnt4));
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur_valid = 1'b0; cur_fs = 1'b0;
      drive();
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    cur_valid = 1'b0; cur_fs = 1'b1;
    drive();
    @(negedge clk);
    cur_fs = 1'b0;
    drive();
  endtask

  // One isolated window; outputs checked against literal expectations.
  task automatic one_win(input string name, input logic [7:0] thr, input logic en,
                         input logic exp_def, input logic [7:0] exp_pix);
    @(negedge clk);
    cur_valid = 1'b1; cur_thr = thr; cur_en = en; cur_fs = 1'b0;
    drive();
    @(negedge clk);
    cur_valid = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 32'(o_line_valid), 32'd1);
    chk({name, "_defect"}, 32'(o_defect), 32'(exp_def));
    chk({name, "_pixel"}, 32'(o_pixel), 32'(exp_pix));
  endtask

  task automatic rand_win();
    int mode;
    mode  = $urandom_range(0, 3);
    win_c = 8'($urandom_range(0, 255));
    if (mode == 1 || mode == 3) begin
      if (win_c == 8'd0) win_c = 8'd1;
      for (int k = 0; k < 8; k++) win_n[k] = 8'($urandom_range(0, int'(win_c) - 1));
      if (mode == 3) win_n[$urandom_range(0, 7)] = win_c;
    end else if (mode == 2) begin
      if (win_c == 8'd255) win_c = 8'd254;
      for (int k = 0; k < 8; k++) win_n[k] = 8'($urandom_range(int'(win_c) + 1, 255));
    end else begin
      for (int k = 0; k < 8; k++) win_n[k] = 8'($urandom_range(0, 255));
    end
    cur_thr   = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 80));
    cur_en    = 1'($urandom_range(0, 1));
    cur_valid = ($urandom_range(0, 3) != 0);
    cur_fs    = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    reset_n = 1'b0;
    set_uniform(8'd0, 8'd0);
    cur_valid = 1'b0; cur_en = 1'b0; cur_fs = 1'b0; cur_thr = 8'd0;
    drive();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_line_valid), 32'd0);
    chk("rst_pixel", 32'(o_pixel), 32'd0);
    chk("rst_cnt", 32'(o_defect_cnt), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Hot pixel and threshold edges.
    pulse_fs();
    set_uniform(8'd200, 8'd100);
    one_win("hot", 8'd50, 1'b1, 1'b1, 8'd100);
    chk("hot_cnt", 32'(o_defect_cnt), 32'd1);
    one_win("thr100", 8'd100, 1'b1, 1'b0, 8'd200);
    one_win("thr99", 8'd99, 1'b1, 1'b1, 8'd100);
    set_uniform(8'd255, 8'd0);
    one_win("thr255", 8'd255, 1'b1, 1'b0, 8'd255);
    one_win("thr254", 8'd254, 1'b1, 1'b1, 8'd0);

    // Dead pixel with rounding, then a zero delta blocking detection.
    set_uniform(8'd10, 8'd120);
    win_n[1] = 8'd100; win_n[3] = 8'd101; win_n[4] = 8'd101; win_n[6] = 8'd101;
    one_win("dead", 8'd20, 1'b1, 1'b1, 8'd101);
    win_n[0] = 8'd10;
    one_win("dead_zero", 8'd20, 1'b1, 1'b0, 8'd10);

    // Bypass streaming: 7 hot windows; frame start meets the 7th at output.
    pulse_fs();
    set_uniform(8'd200, 8'd100);
    cur_thr = 8'd50; cur_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 8) begin
        chk("bypass_cnt6", 32'(o_defect_cnt), 32'd6);
        chk("bypass_pixel", 32'(o_pixel), 32'd200);
        chk("bypass_defect", 32'(o_defect), 32'd1);
      end
      if (i == 9) chk("fs_coincident_cnt", 32'(o_defect_cnt), 32'd1);
      cur_valid = (i < 7);
      cur_fs    = (i == 8);
      drive();
    end

    // Saturation of the 4-bit counter.
    pulse_fs();
    cur_en = 1'b1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      cur_valid = (i < 20);
      drive();
    end
    chk("sat_cnt4", 32'(o_defect_cnt4), 32'd15);
    chk("sat_cnt16", 32'(o_defect_cnt), 32'd20);

    // Randomized stream.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rand_win();
      drive();
    end
    idle(4);

    // Asynchronous reset with two windows in flight.
    set_uniform(8'd200, 8'd100);
    cur_thr = 8'd50; cur_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cur_valid = 1'b1;
      drive();
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_line_valid), 32'd0);
    chk("arst_pixel", 32'(o_pixel), 32'd0);
    chk("arst_defect", 32'(o_defect), 32'd0);
    chk("arst_cnt", 32'(o_defect_cnt4), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(4);
    chk("post_rst_idle", 32'(o_line_valid), 32'd0);
    @(negedge clk);
    cur_valid = 1'b1;
    drive();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      cur_valid = 1'b0;
      drive();
      chk("post_rst_lat", 32'(o_line_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
